wrr_arbiter: RTL and testbench
==============================

Name: wrr_arbiter

Overview:
- Parametrised weighted round-robin arbiter; successor to the fixed 4-requester round-robin arbiter.
- Grants one of N requesters per cycle with a registered one-hot grant.
- Each requester may hold its grant for up to a programmable weight of consecutive cycles before the round-robin pointer advances.
- Sits between N bus masters and a shared resource; no bubble cycles on hand-over.

Parameters:
- N, 4, number of requesters (2..32).
- WW, 4, bits per weight field; max burst = 2^WW-1 cycles.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- req  input  N  request vector, bit i = requester i.
- weight  input  N*WW  per-requester burst limit; field i at bits [i*WW +: WW]; sampled only when requester i is granted.
- gnt  output  N  registered one-hot grant (all-zero when idle).
- gnt_valid  output  1  OR of gnt, registered.
- gnt_id  output  clog2(N)  index of the granted requester; 0 when idle.

Behaviour:
- Reset (clk edge with rst=0):
  - gnt=0, gnt_valid=0, gnt_id=0, state=IDLE, burst count=0.
  - Pointer = N-1, so requester 0 has first priority.
  - Mid-burst reset drops the grant at that edge, with no completion.
- States:
  - IDLE: no owner.
    - If req!=0, the edge grants the first requesting index scanning upward from pointer+1 (mod N), then goes to GRANT.
  - GRANT: owner o; latched weight wl = weight field o at grant edge, with 0 treated as 1; count starts at 1.
- Release in GRANT, evaluated each edge: req[o]=0, or count==wl.
  - On release, the same edge picks the next owner from the current req, scanning from o+1 (mod N).
  - The pointer becomes o.
  - If some request exists: new grant, count=1, new wl latched, stay in GRANT.
    - This includes o itself re-granted when it is the sole requester.
  - Else: gnt=0, state=IDLE.
- No release: hold gnt, count+1.
- Latency: req sampled at edge k produces gnt at edge k (registered), so it is visible for the cycle after edge k. Minimum 1 cycle from req rise to gnt when idle.
- Requests from non-owners never pre-empt a burst.
- Weight changes while granted are ignored until the next grant of that requester.
- Count width is WW; it never exceeds wl, so no wrap.
- gnt is always one-hot or zero; gnt_id and gnt_valid are consistent with gnt on the same cycle.
- N not a power of two: pointer modulo wrap N-1→0 explicitly; indices ≥N are never granted.

Decomposition:
- Package wrr_arb_pkg: state enum {IDLE, GRANT}; function clog2-based width helper; constant for weight-0→1 substitution.
- Sub-module rr_pick: combinational rotating priority encoder, N-bit req plus pointer in, one-hot plus index plus any out.
  - Instantiated once; the parent holds the FSM, pointer, count and weight latch.

Test Plan:
1. Reset priority: rst=0 for 5 cycles with req=4'b1111 → gnt=0, gnt_valid=0 throughout. At the first edge with rst=1, gnt=4'b0001 and gnt_id=0.
2. Plain round robin: all weights=1, req=4'b1111 held → gnt 0001,0010,0100,1000,0001 on successive cycles, no zero cycles.
3. Weighted burst: weight[2]=3, others 1, req=4'b1111 → gnt 0001,0010,0100,0100,0100,1000,0001.
4. Early release: weight[1]=4, req=4'b1010; req1 drops after 2 granted cycles → gnt1 for 2 cycles, then gnt=1000 at the edge sampling req1=0.
5. Sole requester plus weight 0: only req2=1, weight[2]=2 → gnt=0100 continuously, internal count 1,2,1,2. With weight[2]=0, count stays 1 and gnt stays 0100.
6. Reset mid-burst and N=5: N=5, weight[4]=7, req=5'b10000, rst=0 at the 3rd burst cycle → gnt=0 at that edge. After rst=1 with req=5'b10001, gnt=00001 first, then 10000.

Source files
------------

// File: rtl/wrr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package wrr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // A programmed weight of zero still grants one cycle.
    localparam int WEIGHT_ZERO_SUBST = 1;

    // Index width for n requesters, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wrr_arbiter_if.sv
// Request/grant bundle between the bus masters and the arbiter.
interface wrr_arbiter_if
    import wrr_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int WW = 4
);
    localparam int IW = idx_width(N);

    logic [N-1:0]    req;
    logic [N*WW-1:0] weight;
    logic [N-1:0]    gnt;
    logic            gnt_valid;
    logic [IW-1:0]   gnt_id;

    modport master (
        output req,
        output weight,
        input  gnt,
        input  gnt_valid,
        input  gnt_id
    );

    modport slave (
        input  req,
        input  weight,
        output gnt,
        output gnt_valid,
        output gnt_id
    );
endinterface

// File: rtl/wrr_arbiter_rr_pick.sv
// Rotating priority encoder: first set request strictly after ptr, wrapping at N.
module rr_pick
    import wrr_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan ptr+1 .. ptr+N modulo N; the first hit wins, later hits are ignored.
    always_comb begin
        logic [IW-1:0] pos;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = '0;
        for (int k = 1; k <= N; k++) begin
            pos = IW'((int'(ptr) + k) % N);
            if (!any && req[pos]) begin
                onehot[pos] = 1'b1;
                idx         = pos;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: registered one-hot grant, per-requester burst limit.
//
// state | meaning
// IDLE  | no owner, grant outputs all-zero
// GRANT | gnt_id owns the resource; cnt cycles used out of latched weight wl
module wrr_arbiter
    import wrr_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int WW = 4
) (
    input logic          clk,
    input logic          rst,
    wrr_arbiter_if.slave bus
);

    localparam int IW = idx_width(N);

    arb_state_t    state;
    logic [IW-1:0] ptr;
    logic [WW-1:0] cnt;
    logic [WW-1:0] wl;

    logic [N-1:0]  pick_onehot;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] pick_ptr;
    logic          pick_any;
    logic          release_now;
    logic [WW-1:0] pick_w;
    logic [WW-1:0] wfield [N];

    for (genvar i = 0; i < N; i++) begin : g_wfield
        assign wfield[i] = bus.weight[i*WW +: WW];
    end

    // While granted, the next owner is searched from just after the current owner.
    assign pick_ptr    = (state == GRANT) ? bus.gnt_id : ptr;
    assign release_now = (state == GRANT) && (!bus.req[bus.gnt_id] || (cnt == wl));
    assign pick_w      = (wfield[pick_idx] == '0) ? WW'(WEIGHT_ZERO_SUBST) : wfield[pick_idx];

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req    (bus.req),
        .ptr    (pick_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Grant FSM: hand over on release (no bubble), otherwise extend the burst.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            ptr           <= IW'(N - 1);
            cnt           <= '0;
            wl            <= '0;
            bus.gnt       <= '0;
            bus.gnt_valid <= 1'b0;
            bus.gnt_id    <= '0;
        end else if ((state == IDLE) || release_now) begin
            if (release_now) begin
                ptr <= bus.gnt_id;
            end
            if (pick_any) begin
                state         <= GRANT;
                cnt           <= WW'(1);
                wl            <= pick_w;
                bus.gnt       <= pick_onehot;
                bus.gnt_valid <= 1'b1;
                bus.gnt_id    <= pick_idx;
            end else begin
                state         <= IDLE;
                cnt           <= '0;
                bus.gnt       <= '0;
                bus.gnt_valid <= 1'b0;
                bus.gnt_id    <= '0;
            end
        end else begin
            cnt <= cnt + WW'(1);
        end
    end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter: N=4 and N=5 instances against an integer-level model,
// plus hand-computed grant/count sequences.
module tb_wrr_arbiter;
    import wrr_arb_pkg::*;

    logic clk = 1'b0;
    logic rst4;
    logic rst5;

    always #5 clk = ~clk;

    wrr_arbiter_if #(.N(4), .WW(4)) if4 ();
    wrr_arbiter_if #(.N(5), .WW(4)) if5 ();

    wrr_arbiter #(.N(4), .WW(4)) dut4 (.clk(clk), .rst(rst4), .bus(if4.slave));
    wrr_arbiter #(.N(5), .WW(4)) dut5 (.clk(clk), .rst(rst5), .bus(if5.slave));

    typedef struct {
        bit seen;
        int own;
        int cnt;
        int wl;
        int ptr;
    } mstate_t;

    mstate_t m4 = '{0, -1, 0, 0, 0};
    mstate_t m5 = '{0, -1, 0, 0, 0};

    int n_tests = 0;
    int n_fail  = 0;

    string       lit_name = "";
    logic        lit4_en  = 1'b0;
    logic [3:0]  lit4_exp = '0;
    logic        lit5_en  = 1'b0;
    logic [4:0]  lit5_exp = '0;
    logic        litc_en  = 1'b0;
    logic [31:0] litc_exp = '0;

    function automatic int wfield(input logic [127:0] w, input int i);
        logic [127:0] f;
        f = (w >> (i * 4)) & 128'hF;
        return int'(f[31:0]);
    endfunction

    // One clock edge of the arbiter described with plain integers.
    function automatic mstate_t model_step(input mstate_t s, input int n, input logic [31:0] r,
                                           input logic [127:0] w, input logic rstn);
        mstate_t t;
        int      start;
        bit      scan;
        t     = s;
        start = 0;
        scan  = 0;
        if (!rstn) begin
            t.seen = 1;
            t.own  = -1;
            t.cnt  = 0;
            t.wl   = 0;
            t.ptr  = n - 1;
            return t;
        end
        if (!t.seen) return t;
        if (t.own < 0) begin
            start = t.ptr;
            scan  = 1;
        end else if (!r[t.own] || t.cnt == t.wl) begin
            t.ptr = t.own;
            start = t.own;
            scan  = 1;
        end else begin
            t.cnt = t.cnt + 1;
        end
        if (scan) begin
            t.own = -1;
            for (int k = 1; k <= n; k++) begin
                int i;
                i = (start + k) % n;
                if (t.own < 0 && r[i]) t.own = i;
            end
            if (t.own >= 0) begin
                t.cnt = 1;
                t.wl  = (wfield(w, t.own) == 0) ? 1 : wfield(w, t.own);
            end else begin
                t.cnt = 0;
            end
        end
        return t;
    endfunction

    function automatic logic [31:0] mgnt(input mstate_t s);
        return (s.own < 0) ? 32'd0 : (32'd1 << s.own);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance the models on the same edge the DUTs see.
    always @(posedge clk) begin
        m4 = model_step(m4, 4, 32'(if4.req), 128'(if4.weight), rst4);
        m5 = model_step(m5, 5, 32'(if5.req), 128'(if5.weight), rst5);
    end

    // Compare DUT outputs with the models and any literal expectation, away from the edge.
    always @(negedge clk) begin
        if (m4.seen) begin
            check("n4 gnt", 32'(if4.gnt), mgnt(m4));
            check("n4 gnt_valid", 32'(if4.gnt_valid), (m4.own >= 0) ? 32'd1 : 32'd0);
            check("n4 gnt_id", 32'(if4.gnt_id), (m4.own < 0) ? 32'd0 : 32'(m4.own));
            if (m4.own >= 0) check("n4 cnt", 32'(dut4.cnt), 32'(m4.cnt));
        end
        if (m5.seen) begin
            check("n5 gnt", 32'(if5.gnt), mgnt(m5));
            check("n5 gnt_valid", 32'(if5.gnt_valid), (m5.own >= 0) ? 32'd1 : 32'd0);
            check("n5 gnt_id", 32'(if5.gnt_id), (m5.own < 0) ? 32'd0 : 32'(m5.own));
            if (m5.own >= 0) check("n5 cnt", 32'(dut5.cnt), 32'(m5.cnt));
        end
        if (lit4_en) begin
            check(lit_name, 32'(if4.gnt), 32'(lit4_exp));
            check({lit_name, " model"}, mgnt(m4), 32'(lit4_exp));
        end
        if (lit5_en) begin
            check(lit_name, 32'(if5.gnt), 32'(lit5_exp));
            check({lit_name, " model"}, mgnt(m5), 32'(lit5_exp));
        end
        if (litc_en) begin
            check({lit_name, " cnt"}, 32'(dut4.cnt), litc_exp);
            check({lit_name, " model cnt"}, 32'(m4.cnt), litc_exp);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic step4(input string nm, input logic [3:0] e);
        lit_name = nm;
        lit4_exp = e;
        lit4_en  = 1'b1;
        tick();
        lit4_en  = 1'b0;
    endtask

    task automatic step4c(input string nm, input logic [3:0] e, input int c);
        litc_exp = 32'(c);
        litc_en  = 1'b1;
        step4(nm, e);
        litc_en  = 1'b0;
    endtask

    task automatic step5(input string nm, input logic [4:0] e);
        lit_name = nm;
        lit5_exp = e;
        lit5_en  = 1'b1;
        tick();
        lit5_en  = 1'b0;
    endtask

    initial begin
        rst4       = 1'b0;
        rst5       = 1'b0;
        if4.req    = 4'b1111;
        if4.weight = 16'h1111;
        if5.req    = '0;
        if5.weight = 20'h11111;

        // reset priority
        repeat (5) step4("t1 in reset", 4'b0000);
        rst4 = 1'b1;
        step4("t1 first grant", 4'b0001);

        // plain round robin
        step4("t2 rr 1", 4'b0010);
        step4("t2 rr 2", 4'b0100);
        step4("t2 rr 3", 4'b1000);
        step4("t2 rr wrap", 4'b0001);

        // weighted burst
        rst4 = 1'b0;
        step4("t3 reset", 4'b0000);
        rst4       = 1'b1;
        if4.weight = 16'h1311;
        step4("t3 b0", 4'b0001);
        step4("t3 b1", 4'b0010);
        step4("t3 b2", 4'b0100);
        step4("t3 b3", 4'b0100);
        step4("t3 b4", 4'b0100);
        step4("t3 b5", 4'b1000);
        step4("t3 b6", 4'b0001);

        // early release
        rst4 = 1'b0;
        step4("t4 reset", 4'b0000);
        rst4       = 1'b1;
        if4.weight = 16'h1141;
        if4.req    = 4'b1010;
        step4("t4 g1a", 4'b0010);
        step4("t4 g1b", 4'b0010);
        if4.req = 4'b1000;
        step4("t4 handover", 4'b1000);

        // sole requester, then weight zero
        rst4    = 1'b0;
        if4.req = 4'b0100;
        step4("t5 reset", 4'b0000);
        rst4       = 1'b1;
        if4.weight = 16'h1211;
        step4c("t5 w2 c1", 4'b0100, 1);
        step4c("t5 w2 c2", 4'b0100, 2);
        step4c("t5 w2 c1b", 4'b0100, 1);
        step4c("t5 w2 c2b", 4'b0100, 2);
        if4.weight = 16'h1011;
        step4c("t5 w0 a", 4'b0100, 1);
        step4c("t5 w0 b", 4'b0100, 1);
        step4c("t5 w0 c", 4'b0100, 1);
        if4.req = 4'b0000;
        step4("t5 idle", 4'b0000);
        if4.req = 4'b0001;
        step4("t5 idle latency", 4'b0001);
        if4.req = 4'b0000;

        // N=5, reset mid-burst
        if5.weight = 20'h71111;
        if5.req    = 5'b10000;
        rst5       = 1'b1;
        step5("t6 burst 1", 5'b10000);
        step5("t6 burst 2", 5'b10000);
        rst5 = 1'b0;
        step5("t6 reset mid", 5'b00000);
        rst5    = 1'b1;
        if5.req = 5'b10001;
        step5("t6 after 0", 5'b00001);
        step5("t6 after 4", 5'b10000);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
